// File: rtl/pipo_pkg.sv
// Shared types for the universal PIPO shift register: register modes, FSM states, burst direction codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipo_pkg;

   typedef enum logic [2:0] {
      HOLD = 3'd0,
      LOAD = 3'd1,
      SHL  = 3'd2,
      SHR  = 3'd3,
      ROL  = 3'd4,
      ROR  = 3'd5,
      CLR  = 3'd6,
      RSVD = 3'd7
   } mode_e;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam logic DIR_MSB_FIRST = 1'b0;
   localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/pipo_universal_shift_if.sv
// Bus bundle for pipo_universal_shift: control/data inputs and register/serial outputs.
// Latency: n/a (wiring only); slave = the register, master = whoever drives it.
// Backpressure: none; all outputs come straight from registers in the slave.
//   MODE/DATA/SER_IN/START/DIR : to the register
//   OUT/SER_OUT/BUSY/DONE      : from the register
interface pipo_universal_shift_if #(
   parameter int WIDTH = 8
);
   import pipo_pkg::*;

   mode_e             MODE;
   logic [WIDTH-1:0]  DATA;
   logic              SER_IN;
   logic              START;
   logic              DIR;
   logic [WIDTH-1:0]  OUT;
   logic              SER_OUT;
   logic              BUSY;
   logic              DONE;

   modport master (
      output MODE, DATA, SER_IN, START, DIR,
      input  OUT, SER_OUT, BUSY, DONE
   );

   modport slave (
      input  MODE, DATA, SER_IN, START, DIR,
      output OUT, SER_OUT, BUSY, DONE
   );

endinterface

// File: rtl/shift_bit_counter.sv
// Loadable down-counter tracking the remaining bits of a serializer burst; flags the last bit.
// Latency: load/decrement take effect at the next edge; o_is_last is registered-state derived.
// Backpressure: none; saturates at zero instead of wrapping.
//   i_load/i_load_val : load a new count (wins over decrement)
//   i_dec             : decrement by one
//   o_is_last         : count equals one
module shift_bit_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_is_last
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_is_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/pipo_universal_shift.sv
// Parallel-in/parallel-out register with shift/rotate/clear modes and a WIDTH-bit serializer burst.
// Latency: every operation lands at the next rising edge; burst = WIDTH BUSY cycles then one DONE cycle.
// Backpressure: none; MODE/START/DIR are ignored while BUSY, START is honoured again in the DONE cycle.
//   clk, rst (async active-low) ; bus.slave carries MODE/DATA/SER_IN/START/DIR in, OUT/SER_OUT/BUSY/DONE out
module pipo_universal_shift
   import pipo_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   pipo_universal_shift_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] r_out;
   logic             r_dir;
   logic             r_done;
   state_e           r_state;

   logic             w_start_acc;
   logic             w_is_last;

   assign w_start_acc = (r_state == IDLE) && bus.START;

   shift_bit_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_start_acc),
      .i_load_val (CNT_W'(WIDTH)),
      .i_dec      (r_state == SHIFT),
      .o_is_last  (w_is_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out   <= '0;
         r_dir   <= DIR_MSB_FIRST;
         r_done  <= 1'b0;
         r_state <= IDLE;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.START) begin
                  // START outranks MODE: load the word and arm the burst
                  r_out   <= bus.DATA;
                  r_dir   <= bus.DIR;
                  r_state <= SHIFT;
               end else begin
                  case (bus.MODE)
                     LOAD:    r_out <= bus.DATA;
                     SHL:     r_out <= {r_out[WIDTH-2:0], bus.SER_IN};
                     SHR:     r_out <= {bus.SER_IN, r_out[WIDTH-1:1]};
                     ROL:     r_out <= {r_out[WIDTH-2:0], r_out[WIDTH-1]};
                     ROR:     r_out <= {r_out[0], r_out[WIDTH-1:1]};
                     CLR:     r_out <= '0;
                     default: r_out <= r_out;
                  endcase
               end
            end
            SHIFT: begin
               if (r_dir == DIR_LSB_FIRST) begin
                  r_out <= {bus.SER_IN, r_out[WIDTH-1:1]};
               end else begin
                  r_out <= {r_out[WIDTH-2:0], bus.SER_IN};
               end
               if (w_is_last) begin
                  r_state <= IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.OUT     = r_out;
   assign bus.SER_OUT = (r_dir == DIR_LSB_FIRST) ? r_out[0] : r_out[WIDTH-1];
   assign bus.BUSY    = (r_state == SHIFT);
   assign bus.DONE    = r_done;

endmodule

// File: tb/tb_pipo_universal_shift.sv
// Self-checking bench for pipo_universal_shift (WIDTH=8): vector table, burst sequences, reset abort, random run.
// Latency: outputs sampled 2 time units after each rising edge.
// Backpressure: n/a.
module tb_pipo_universal_shift;
   import pipo_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipo_universal_shift_if #(.WIDTH(8)) bus ();

   pipo_universal_shift #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: register value as an integer, bits left in the burst
   int m_out    = 0;
   int m_remain = 0;
   int m_dir    = 0;
   int m_done   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_out = 0; m_remain = 0; m_dir = 0; m_done = 0;
   endtask

   // One clock edge worth of behaviour, from the current inputs
   task automatic model_step();
      int ser;
      ser    = int'(bus.SER_IN);
      m_done = 0;
      if (m_remain > 0) begin
         if (m_dir == 1) m_out = m_out / 2 + ser * 128;
         else            m_out = (m_out * 2 + ser) % 256;
         m_remain--;
         if (m_remain == 0) m_done = 1;
      end else if (bus.START) begin
         m_out    = int'(bus.DATA);
         m_dir    = int'(bus.DIR);
         m_remain = 8;
      end else begin
         case (int'(bus.MODE))
            1: m_out = int'(bus.DATA);
            2: m_out = (m_out * 2 + ser) % 256;
            3: m_out = m_out / 2 + ser * 128;
            4: m_out = (m_out * 2) % 256 + m_out / 128;
            5: m_out = m_out / 2 + (m_out % 2) * 128;
            6: m_out = 0;
            default: ;
         endcase
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #2;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".out"},  int'(bus.OUT), m_out);
      chk({tag, ".ser"},  int'(bus.SER_OUT), (m_dir == 1) ? (m_out % 2) : (m_out / 128));
      chk({tag, ".busy"}, int'(bus.BUSY), (m_remain > 0) ? 1 : 0);
      chk({tag, ".done"}, int'(bus.DONE), m_done);
   endtask

   task automatic drive(input mode_e md, input logic [7:0] d, input logic s, input logic st, input logic dr);
      bus.MODE = md; bus.DATA = d; bus.SER_IN = s; bus.START = st; bus.DIR = dr;
   endtask

   // Starts a burst and checks the serial stream against a constant bit pattern (bit k = k-th bit out)
   task automatic burst(input string tag, input logic [7:0] d, input logic dr, input logic s,
                        input logic [7:0] exp_bits, input logic [7:0] exp_after);
      drive(HOLD, d, s, 1'b1, dr);
      tick();
      bus.START = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("%s.busy%0d", tag, k), int'(bus.BUSY), 1);
         chk($sformatf("%s.bit%0d", tag, k), int'(bus.SER_OUT), int'(exp_bits[7-k]));
         check_model($sformatf("%s.m%0d", tag, k));
         tick();
      end
      chk({tag, ".done"}, int'(bus.DONE), 1);
      chk({tag, ".busy_end"}, int'(bus.BUSY), 0);
      chk({tag, ".out_end"}, int'(bus.OUT), int'(exp_after));
      tick();
      chk({tag, ".done_clr"}, int'(bus.DONE), 0);
   endtask

   typedef struct {
      mode_e      mode;
      logic [7:0] data;
      logic       ser;
      logic [7:0] exp_out;
   } vec_t;

   vec_t vt[$];
   logic [7:0] seq_b;
   logic       tog;
   int         n_done;

   initial begin
      vt.push_back('{LOAD, 8'hA5, 1'b0, 8'hA5});
      vt.push_back('{HOLD, 8'h00, 1'b1, 8'hA5});
      vt.push_back('{HOLD, 8'hFF, 1'b0, 8'hA5});
      vt.push_back('{HOLD, 8'h3C, 1'b1, 8'hA5});
      vt.push_back('{LOAD, 8'h81, 1'b0, 8'h81});
      vt.push_back('{SHL,  8'h00, 1'b1, 8'h03});
      vt.push_back('{LOAD, 8'h81, 1'b0, 8'h81});
      vt.push_back('{SHR,  8'hFF, 1'b0, 8'h40});
      vt.push_back('{LOAD, 8'h81, 1'b0, 8'h81});
      vt.push_back('{ROL,  8'h00, 1'b0, 8'h03});
      vt.push_back('{LOAD, 8'h81, 1'b1, 8'h81});
      vt.push_back('{ROR,  8'h00, 1'b0, 8'hC0});
      vt.push_back('{RSVD, 8'h55, 1'b1, 8'hC0});
      vt.push_back('{CLR,  8'hFF, 1'b1, 8'h00});
      vt.push_back('{RSVD, 8'h55, 1'b1, 8'h00});

      drive(HOLD, 8'h00, 1'b0, 1'b0, 1'b0);

      // 1. reset state
      #12;
      chk("rst.out",  int'(bus.OUT), 0);
      chk("rst.busy", int'(bus.BUSY), 0);
      chk("rst.done", int'(bus.DONE), 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #2;

      // 1-2. register modes from the vector table
      foreach (vt[i]) begin
         drive(vt[i].mode, vt[i].data, vt[i].ser, 1'b0, 1'b0);
         tick();
         chk($sformatf("vec%0d.out", i), int'(bus.OUT), int'(vt[i].exp_out));
         chk($sformatf("vec%0d.busy", i), int'(bus.BUSY), 0);
         check_model($sformatf("vec%0d", i));
      end

      // 3. MSB-first, zero fill
      burst("msb", 8'hB4, 1'b0, 1'b0, 8'b1011_0100, 8'h00);
      // 4. LSB-first, one fill
      burst("lsb", 8'h0F, 1'b1, 1'b1, 8'b1111_0000, 8'hFF);

      // 5. inputs ignored while busy, then a back-to-back START in the DONE cycle
      seq_b = 8'b1001_0110;
      drive(HOLD, 8'h96, 1'b0, 1'b1, 1'b0);
      tick();
      bus.MODE = CLR;
      bus.DATA = 8'h3C;
      tog = 1'b0;
      n_done = 0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("ign.bit%0d", k), int'(bus.SER_OUT), int'(seq_b[7-k]));
         if (bus.DONE) n_done++;
         check_model($sformatf("ign.m%0d", k));
         tog = ~tog;
         bus.DIR = tog;
         tick();
      end
      if (bus.DONE) n_done++;
      chk("ign.done_cycle_busy", int'(bus.BUSY), 0);
      bus.DIR = 1'b0;
      tick();
      if (bus.DONE) n_done++;
      chk("ign.done_count", n_done, 1);
      chk("b2b.busy", int'(bus.BUSY), 1);
      chk("b2b.out", int'(bus.OUT), 8'h3C);
      bus.START = 1'b0;
      bus.MODE  = HOLD;
      for (int k = 0; k < 9; k++) begin
         check_model($sformatf("b2b.m%0d", k));
         tick();
      end
      check_model("b2b.tail");

      // 6. async reset on the 4th busy cycle
      drive(HOLD, 8'hA5, 1'b1, 1'b1, 1'b0);
      tick();
      bus.START = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      chk("abort.busy_before", int'(bus.BUSY), 1);
      #1;
      rst = 1'b0;
      #1;
      model_reset();
      chk("abort.out",  int'(bus.OUT), 0);
      chk("abort.busy", int'(bus.BUSY), 0);
      chk("abort.done", int'(bus.DONE), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("abort.nodone%0d", k), int'(bus.DONE), 0);
         check_model($sformatf("abort.m%0d", k));
         tick();
      end
      burst("post", 8'h5A, 1'b1, 1'b0, 8'b0101_1010, 8'h00);

      // random run against the model
      for (int c = 0; c < 400; c++) begin
         drive(mode_e'($urandom_range(0, 7)), 8'($urandom), 1'($urandom),
               ($urandom_range(0, 7) == 0), 1'($urandom));
         tick();
         check_model($sformatf("rnd%0d", c));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pipo_universal_shift.md
Name: pipo_universal_shift

Overview:
Parametrised successor to the team's 8-bit parallel-load register. It adds shift, rotate and clear modes with serial input, plus an automatic serializer burst (START -> WIDTH serial bits out, with BUSY and DONE). It sits between parallel datapaths and serial links in the P-series labs, for example to feed a UART or SPI-style transmitter.

Parameters:
WIDTH, 8, register width in bits (>= 2).
CNT_W, $clog2(WIDTH+1), burst counter width (derived; do not override).

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous active-low reset.
MODE  input  3  register operation in IDLE: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 CLR, 7 HOLD (reserved).
DATA  input  WIDTH  parallel load data.
SER_IN  input  1  fill bit for SHL/SHR and for burst shifts.
START  input  1  begin serializer burst (sampled in IDLE only).
DIR  input  1  burst direction: 0 MSB-first (shift left), 1 LSB-first (shift right).
OUT  output  WIDTH  register contents.
SER_OUT  output  1  current serial bit.
BUSY  output  1  burst in progress.
DONE  output  1  one-cycle pulse at burst end.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst).
- Reset (rst=0, asynchronous): OUT=0, counter=0, latched dir=0, state=IDLE, BUSY=0, DONE=0. Reset asserted mid-burst aborts the burst immediately, with no DONE.
- All outputs are registered or derived from registers. No combinational path from inputs to outputs.
- FSM states: IDLE, SHIFT.
- IDLE, START=0: MODE applied at each edge:
  - HOLD: OUT unchanged.
  - LOAD: OUT<=DATA.
  - SHL: OUT<={OUT[W-2:0],SER_IN}.
  - SHR: OUT<={SER_IN,OUT[W-1:1]}.
  - ROL: OUT<={OUT[W-2:0],OUT[W-1]}.
  - ROR: OUT<={OUT[0],OUT[W-1:1]}.
  - CLR: OUT<=0.
  - 7: HOLD.
- IDLE, START=1 (START has priority over MODE): OUT<=DATA, dir latched from DIR, counter<=WIDTH, state->SHIFT.
- SHIFT: at each edge, shift in the latched dir, filling with SER_IN, and decrement the counter. When the counter equals 1 at the edge: state->IDLE, DONE<=1 for exactly one cycle. MODE, START and DIR are ignored while in SHIFT.
- SER_OUT = OUT[WIDTH-1] when latched dir=0, OUT[0] when latched dir=1, in all states.
- Timing, START sampled at edge t:
  - BUSY=1 during cycles t+1 .. t+WIDTH (exactly WIDTH cycles).
  - SER_OUT presents bit k of the burst during cycle t+1+k.
  - DONE=1 during cycle t+WIDTH+1, with BUSY=0 in that same cycle.
- Back-to-back bursts: START may be asserted in the DONE cycle and is accepted (state is IDLE). The next burst then begins with BUSY high the following cycle.
- BUSY = (state==SHIFT). DONE is a registered flag, cleared on every edge where it is not being set.
- Counter never underflows. It is 0 in IDLE.

Decomposition:
- Package pipo_pkg:
  - typedef enum logic [2:0] mode_e (HOLD, LOAD, SHL, SHR, ROL, ROR, CLR, RSVD).
  - typedef enum logic state_e (IDLE, SHIFT).
  - localparams DIR_MSB_FIRST=0, DIR_LSB_FIRST=1.
- One sub-module is natural: shift_bit_counter, a loadable down-counter (load value, decrement enable, is_last flag), parametrised by CNT_W.

Test Plan:
1. Reset and load, WIDTH=8: hold rst=0 -> OUT=0x00, BUSY=0, DONE=0. Release rst, MODE=LOAD, DATA=0xA5 -> OUT=0xA5 next cycle. MODE=HOLD for 3 cycles -> OUT stays 0xA5.
2. Shift and rotate modes, starting from OUT=0x81:
   - SHL with SER_IN=1 -> 0x03.
   - Reload 0x81, SHR with SER_IN=0 -> 0x40.
   - Reload 0x81, ROL -> 0x03.
   - Reload 0x81, ROR -> 0xC0.
   - CLR -> 0x00.
   - MODE=7 -> OUT unchanged.
3. MSB-first burst: DATA=0xB4, DIR=0, START pulse, SER_IN=0 -> SER_OUT sequence 1,0,1,1,0,1,0,0 over 8 BUSY cycles. Then DONE=1 for one cycle and OUT=0x00.
4. LSB-first burst with fill: DATA=0x0F, DIR=1, SER_IN=1 -> SER_OUT sequence 1,1,1,1,0,0,0,0. DONE at cycle t+9; OUT=0xFF afterwards.
5. Ignored inputs during burst: MODE=CLR, START=1 and toggling DIR throughout the burst -> serial sequence unaffected, exactly one DONE pulse. Then a back-to-back START in the DONE cycle -> second burst begins with no gap cycle.
6. Reset mid-burst: assert rst asynchronously at the 4th BUSY cycle, between edges -> OUT=0, BUSY=0, DONE=0 immediately. After release, IDLE with no DONE pulse. A new burst then runs normally.
